// File: rtl/seq_cla_addsub.sv
// ----------------------------------------------------------------------------
// SeqClaAddSub: multi-cycle carry-lookahead adder/subtractor.
//
// A WIDTH-bit operand pair is processed one GROUP-bit lookahead group per
// clock, least significant group first. Inside a group every carry is formed
// by full lookahead; between groups the carry travels through a register.
// This module replaces the old 4-bit lookahead adder in the ULA datapath. It
// adds subtract mode, a start/busy/done handshake, status flags and
// whole-word generate/propagate outputs.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   start    - operation request, only looked at while idle
//   op_sub   - 0: a + b + cin, 1: a - b (cin ignored)
//   a, b     - operands (WIDTH bits)
//   cin      - carry in, add mode only
//   busy     - high while groups are being computed
//   done     - one-cycle pulse when the result registers are fresh
//   sum      - result (WIDTH bits)
//   cout     - carry out of the MSB (subtract: 1 means no borrow)
//   overflow - signed overflow, carry into MSB xor carry out
//   zero     - sum is all zeros
//   gen_out  - word generate (carry out if carry in were 0)
//   prop_out - word propagate (AND of all a ^ beff bits)
// ----------------------------------------------------------------------------
module seq_cla_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             gen_out,
   output logic             prop_out
);

   localparam int NGRP = WIDTH / GROUP;
   localparam int IW   = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [IW-1:0] LASTIDX = IW'(NGRP - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   stateT            state;
   stateT            nextState;

   logic [WIDTH-1:0] aReg;
   logic [WIDTH-1:0] bReg;
   logic [WIDTH-1:0] partial;
   logic             carry;
   logic             gacc;
   logic             pacc;
   logic [IW-1:0]    idx;

   logic [GROUP-1:0] aGrp;
   logic [GROUP-1:0] bGrp;
   logic [GROUP-1:0] pBits;
   logic [GROUP-1:0] gBits;
   logic [GROUP-1:0] sumGrp;
   logic [GROUP:0]   cGrp;
   logic             gGrp;
   logic             pGrp;
   logic [WIDTH-1:0] nextPartial;
   logic             lastGroup;
   int               base;

   // State register. Reset drops straight back to IDLE, abandoning any
   // operation that was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A start seen in RUN or DONE is simply dropped; it is
   // not remembered for later.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = RUN;
         RUN:     if (lastGroup) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Handshake outputs come straight from the state so they follow a reset
   // immediately.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Lookahead for the group selected by idx. Each carry is built as a
   // sum of products of the generates, propagates and the group carry-in,
   // so no carry depends on the one below it. The group generate is the same
   // expression with the carry-in forced to zero. The new sum bits are ORed
   // into the partial register. This works because the partial register is
   // cleared at start and each group slot is written only once.
   always_comb begin
      base        = int'(idx) * GROUP;
      aGrp        = GROUP'(aReg >> base);
      bGrp        = GROUP'(bReg >> base);
      pBits       = aGrp ^ bGrp;
      gBits       = aGrp & bGrp;
      cGrp        = '0;
      cGrp[0]     = carry;
      for (int i = 0; i < GROUP; i++) begin
         logic pAll;
         pAll = 1'b1;
         for (int j = 0; j <= i; j++) begin
            logic pRun;
            pRun = 1'b1;
            for (int k = j + 1; k <= i; k++) begin
               pRun = pRun & pBits[k];
            end
            cGrp[i+1] = cGrp[i+1] | (gBits[j] & pRun);
            pAll      = pAll & pBits[j];
         end
         cGrp[i+1] = cGrp[i+1] | (pAll & carry);
      end
      gGrp = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
         logic pRun;
         pRun = 1'b1;
         for (int k = j + 1; k < GROUP; k++) begin
            pRun = pRun & pBits[k];
         end
         gGrp = gGrp | (gBits[j] & pRun);
      end
      pGrp        = &pBits;
      sumGrp      = pBits ^ cGrp[GROUP-1:0];
      nextPartial = partial | (WIDTH'(sumGrp) << base);
      lastGroup   = (idx == LASTIDX);
   end

   // Datapath. Start latches the operands, with b inverted and a forced
   // carry-in of 1 for subtraction. Each RUN cycle folds one group into
   // the carry, the partial sum and the word generate/propagate
   // accumulators. The result registers are loaded only on the last group.
   // They hold their value through the next RUN until fresh results arrive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aReg     <= '0;
         bReg     <= '0;
         partial  <= '0;
         carry    <= 1'b0;
         gacc     <= 1'b0;
         pacc     <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         gen_out  <= 1'b0;
         prop_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  aReg    <= a;
                  bReg    <= op_sub ? ~b : b;
                  carry   <= op_sub ? 1'b1 : cin;
                  idx     <= '0;
                  partial <= '0;
                  gacc    <= 1'b0;
                  pacc    <= 1'b1;
               end
            end
            RUN: begin
               partial <= nextPartial;
               carry   <= cGrp[GROUP];
               pacc    <= pacc & pGrp;
               gacc    <= gGrp | (pGrp & gacc);
               idx     <= idx + 1'b1;
               if (lastGroup) begin
                  sum      <= nextPartial;
                  cout     <= cGrp[GROUP];
                  overflow <= cGrp[GROUP-1] ^ cGrp[GROUP];
                  zero     <= (nextPartial == '0);
                  gen_out  <= gGrp | (pGrp & gacc);
                  prop_out <= pacc & pGrp;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
